reg_dump_reader: RTL and testbench

//  Sequential reader for the MIPS register file. On a start pulse it walks

---
 rtl/reg_dump_reader_if.sv | 43 ++++
 rtl/reg_dump_reader.sv | 117 +++++++++++
 tb/tb_reg_dump_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_if.sv
// Register-file read port plus valid/ready dump stream used by reg_dump_reader.
// REG_DUMP_PARITY_EN adds the dump_par signal to both modports.
interface reg_dump_reader_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;
`ifdef REG_DUMP_PARITY_EN
   logic              dump_par;
`endif

   modport master (
      output rf_addr,
      input  rf_data,
      output dump_valid,
      input  dump_ready,
      output dump_idx,
      output dump_data,
`ifdef REG_DUMP_PARITY_EN
      output dump_par,
`endif
      output dump_last
   );

   modport slave (
      input  rf_addr,
      output rf_data,
      input  dump_valid,
      output dump_ready,
      input  dump_idx,
      input  dump_data,
`ifdef REG_DUMP_PARITY_EN
      input  dump_par,
`endif
      input  dump_last
   );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks register-file read port 1 and streams {index, data} beats over valid/ready.
// Optional REG_DUMP_PARITY_EN adds a registered even-parity bit per beat.
module reg_dump_reader #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned FIRST_REG = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               rf_hold,
   reg_dump_reader_if.master  bus
);

   localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;
`ifdef REG_DUMP_PARITY_EN
   logic              par_q, par_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         ptr_q   <= FirstIdx;
         valid_q <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
`ifdef REG_DUMP_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         last_q  <= last_d;
`ifdef REG_DUMP_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      data_d  = data_q;
      last_d  = last_q;
`ifdef REG_DUMP_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRead;
               ptr_d   = FirstIdx;
            end
         end
         StRead: begin
            data_d  = bus.rf_data;
            idx_d   = ptr_q;
            valid_d = 1'b1;
            last_d  = (ptr_q == LastIdx);
`ifdef REG_DUMP_PARITY_EN
            par_d   = ^bus.rf_data;
`endif
            state_d = StSend;
         end
         StSend: begin
            // Beat is held until accepted; ready never feeds valid combinationally.
            if (valid_q && bus.dump_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               if (ptr_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = StRead;
               end
            end
         end
         StDone: begin
            ptr_d   = FirstIdx;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy           = (state_q != StIdle);
   assign rf_hold        = busy;
   assign done           = (state_q == StDone);
   assign bus.rf_addr    = (state_q == StRead) ? ptr_q : '0;
   assign bus.dump_valid = valid_q;
   assign bus.dump_idx   = idx_q;
   assign bus.dump_data  = data_q;
   assign bus.dump_last  = last_q;
`ifdef REG_DUMP_PARITY_EN
   assign bus.dump_par   = par_q;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader: a core-side register file model plus a
// snapshot-based expectation of every dump.
module tb_reg_dump_reader;
   localparam int NUM   = 32;
   localparam int FIRST = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic busy, done, rf_hold;

   reg_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   reg_dump_reader #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_REGS (NUM),
      .FIRST_REG(FIRST)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .rf_hold(rf_hold),
      .bus    (bus.master)
   );

   always #5 clk = ~clk;

   // Core register file: WE3 is gated by rf_hold, RD1 is a combinational read.
   logic [31:0] regs [NUM];
   logic        rf_load = 1'b1;
   logic        we3 = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;

   always_ff @(posedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < NUM; i++) regs[i] <= 32'(i);
      end else if (we3 && !rf_hold) begin
         regs[wa] <= wd;
      end
   end

   assign bus.rf_data = regs[bus.rf_addr];

   int chk_cnt = 0;
   int err_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready high, 1: random ready, 2: stall 5 cycles on idx 7.
   task automatic do_dump(input int mode, input bit restart, input bit poke,
                          input bit start_at_done, input bit check_timing);
      logic [31:0] snap [$];
      logic [4:0]  pidx;
      logic [31:0] pdata;
      bit          pend;
      int          nxt, hold_cnt, done_cnt, done_cyc, last_hs, first_valid;
      snap = {};
      for (int i = FIRST; i < NUM; i++) snap.push_back(regs[i]);
      nxt = FIRST; hold_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
      first_valid = -1; pend = 1'b0; pidx = '0; pdata = '0;
      start = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 1; cyc < 400; cyc++) begin
         start = 1'b0;
         we3   = 1'b0;
         case (mode)
            0: bus.dump_ready = 1'b1;
            1: bus.dump_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (bus.dump_valid && bus.dump_idx == 5'd7 && hold_cnt < 5) begin
                  bus.dump_ready = 1'b0;
                  hold_cnt++;
               end else begin
                  bus.dump_ready = 1'b1;
               end
            end
         endcase
         if (restart && bus.dump_valid && bus.dump_idx == 5'd4) start = 1'b1;
         if (poke && cyc == 2) begin
            we3 = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
         end
         if (start_at_done && last_hs >= 0 && cyc == last_hs + 1) start = 1'b1;
         @(negedge clk);
         if (done_cyc < 0) begin
            check_val("busy_during", 64'(busy), 64'd1);
            check_val("rf_hold_during", 64'(rf_hold), 64'd1);
         end
         if (pend) begin
            check_val("valid_held", 64'(bus.dump_valid), 64'd1);
            check_val("idx_stable", 64'(bus.dump_idx), 64'(pidx));
            check_val("data_stable", 64'(bus.dump_data), 64'(pdata));
         end
         pend = 1'b0;
         if (bus.dump_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (bus.dump_ready) begin
               if (nxt < NUM) begin
                  check_val("beat_idx", 64'(bus.dump_idx), 64'(nxt));
                  check_val("beat_data", 64'(bus.dump_data), 64'(snap[nxt - FIRST]));
                  check_val("beat_last", 64'(bus.dump_last), 64'(nxt == NUM - 1));
`ifdef REG_DUMP_PARITY_EN
                  check_val("beat_par", 64'(bus.dump_par), 64'(^snap[nxt - FIRST]));
`endif
               end else begin
                  check_val("extra_beat", 64'(nxt), 64'(NUM - 1));
               end
               nxt++;
               if (nxt == NUM) last_hs = cyc;
            end else begin
               pend  = 1'b1;
               pidx  = bus.dump_idx;
               pdata = bus.dump_data;
            end
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc > done_cyc) begin
            check_val("busy_after_done", 64'(busy), 64'd0);
            check_val("valid_after_done", 64'(bus.dump_valid), 64'd0);
         end
         if (done_cyc >= 0 && cyc == done_cyc + 2) break;
         @(posedge clk); #1;
      end
      check_val("beat_count", 64'(nxt), 64'(NUM));
      check_val("done_count", 64'(done_cnt), 64'd1);
      check_val("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
      if (check_timing) begin
         check_val("first_valid_cyc", 64'(first_valid), 64'd2);
         check_val("done_cyc", 64'(done_cyc), 64'd65);
      end
      @(posedge clk); #1;
   endtask

   bit found;

   initial begin
      bus.dump_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_hold", 64'(rf_hold), 64'd0);
      check_val("rst_valid", 64'(bus.dump_valid), 64'd0);
      check_val("rst_addr", 64'(bus.rf_addr), 64'd0);
      check_val("rst_last", 64'(bus.dump_last), 64'd0);
      rst = 1'b1;
      rf_load = 1'b0;
      @(posedge clk); #1;
      // Start only samples in idle; no spurious activity without it.
      @(negedge clk);
      check_val("idle_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      do_dump(0, 1'b0, 1'b0, 1'b0, 1'b1);
      do_dump(2, 1'b0, 1'b0, 1'b0, 1'b0);
      do_dump(0, 1'b1, 1'b0, 1'b1, 1'b0);
      do_dump(1, 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("r5_gated", 64'(regs[5]), 64'd5);

      // Abort mid-dump with reset, then restart from index 0.
      found = 1'b0;
      start = 1'b1;
      bus.dump_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.dump_valid && bus.dump_idx == 5'd10) begin
            found = 1'b1;
            break;
         end
      end
      check_val("reach_beat10", 64'(found), 64'd1);
      #1 rst = 1'b0;
      #1;
      check_val("abort_valid", 64'(bus.dump_valid), 64'd0);
      check_val("abort_busy", 64'(busy), 64'd0);
      check_val("abort_hold", 64'(rf_hold), 64'd0);
      check_val("abort_addr", 64'(bus.rf_addr), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      do_dump(0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Random register contents and random back-pressure.
      for (int r = 0; r < 6; r++) begin
         bus.dump_ready = 1'b0;
         for (int k = 0; k < 8; k++) begin
            we3 = 1'b1;
            wa  = 5'($urandom_range(1, NUM - 1));
            wd  = $urandom;
            @(posedge clk); #1;
         end
         we3 = 1'b0;
         do_dump(1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end
endmodule
